bus_memory: RTL

BUS_MEMORY -- requirements
Module: bus_memory

---
 rtl/bus_memory.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bus_memory.sv
// bus_memory: word-addressed memory shared by a byte loader and a CPU bus.
//
// After reset the block sits in LOAD and holds the CPU in reset. It accepts
// loader bytes at incrementing addresses until a byte marked last arrives,
// or the top word is written. It then moves to RUN and serves CPU reads and
// writes on the tri-state data bus, one access per rising edge of mem_clk.
//
// State table:
//   state | meaning
//   LOAD  | loader owns the array, CPU held, bus released
//   RUN   | CPU owns the array, loader ignored until the next reset
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   addr_bus            CPU word address
//   mem_clk             CPU memory-phase strobe (rising edge = one access)
//   mem_rd, mem_wr      CPU read / write request
//   bus                 shared data bus, driven only for RUN reads
//   ld_valid, ld_data,
//   ld_last, ld_ready   loader byte handshake
//   cpu_hold            high while loading (and in reset unless SKIP_LOAD)
//   err_conflict        sticky: strobe seen with mem_rd and mem_wr both high
module bus_memory #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter bit SKIP_LOAD = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr_bus,
  input  logic          mem_clk,
  input  logic          mem_rd,
  input  logic          mem_wr,
  inout  wire  [DW-1:0] bus,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_hold,
  output logic          err_conflict
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam state_t        INIT_STATE = SKIP_LOAD ? RUN : LOAD;
  localparam logic [AW-1:0] LAST_ADDR  = '1;

  state_t        state, state_next;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_clk_q;
  logic          strobe;
  logic          ld_xfer;
  logic          cpu_rd, cpu_wr, cpu_conflict;
  logic          bus_oe;

  always_ff @(posedge clk) begin
    if (reset) state <= INIT_STATE;
    else       state <= state_next;
  end

  // Everything is gated by reset so the reset cycle itself neither loads,
  // drives the bus nor touches the array.
  always_comb begin
    state_next   = state;
    ld_ready     = 1'b0;
    cpu_hold     = 1'b0;
    ld_xfer      = 1'b0;
    cpu_rd       = 1'b0;
    cpu_wr       = 1'b0;
    cpu_conflict = 1'b0;
    bus_oe       = 1'b0;
    strobe       = mem_clk & ~mem_clk_q;
    if (reset) begin
      cpu_hold = !SKIP_LOAD;
    end else begin
      case (state)
        LOAD: begin
          ld_ready = 1'b1;
          cpu_hold = 1'b1;
          ld_xfer  = ld_valid;
          // Stop at the top word so a missing ld_last never wraps onto word 0.
          if (ld_valid && (ld_last || ld_addr == LAST_ADDR)) state_next = RUN;
        end
        RUN: begin
          bus_oe = mem_rd & ~mem_wr;
          if (strobe) begin
            cpu_rd       = mem_rd & ~mem_wr;
            cpu_wr       = mem_wr & ~mem_rd;
            cpu_conflict = mem_rd & mem_wr;
          end
        end
        default: state_next = INIT_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_addr      <= '0;
      rdata        <= '0;
      mem_clk_q    <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      mem_clk_q <= mem_clk;
      if (ld_xfer)      ld_addr      <= ld_addr + 1'b1;
      if (cpu_rd)       rdata        <= mem[addr_bus];
      if (cpu_conflict) err_conflict <= 1'b1;
    end
  end

  // No reset on the array: contents survive reset, including a partial load.
  always_ff @(posedge clk) begin
    if (ld_xfer)     mem[ld_addr]  <= ld_data;
    else if (cpu_wr) mem[addr_bus] <= bus;
  end

  assign bus = bus_oe ? rdata : {DW{1'bz}};

endmodule
